// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART transmit arbiter: per-client byte requests,
// burst locks and the arbiter's acknowledge/ownership status.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_lock;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [2:0]           grant_id;
    logic                 busy;

    modport master (
        output req, req_lock, req_data,
        input  req_ack, grant_id, busy
    );

    modport slave (
        input  req, req_lock, req_data,
        output req_ack, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with optional burst locking and a watchdog on the UART start handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic                uart_transmit,
    output logic [7:0]          uart_tx_byte,
    input  logic                uart_is_transmitting,
    output logic                timeout_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);
    localparam logic [7:0] TIMER_LAST  = 8'(BUSY_TIMEOUT - 1);

    state_t             state;
    logic [2:0]         rr_ptr;
    logic [2:0]         grant_id;
    logic [7:0]         burst_cnt;
    logic [7:0]         timer;
    logic [NUM_REQ-1:0] req_ack;

    // Zero-extended views so a 3-bit requester index can address them directly.
    logic [7:0]  req_ext;
    logic [7:0]  lock_ext;
    logic [63:0] data_ext;
    logic        pick_vld;
    logic [2:0]  pick_id;
    logic [7:0]  pick_byte;
    logic [7:0]  own_byte;
    logic        own_continue;

    assign req_ext  = 8'(bus.req);
    assign lock_ext = 8'(bus.req_lock);
    assign data_ext = 64'(bus.req_data);

    function automatic logic [2:0] next_id(input logic [2:0] id);
        if (int'(id) >= NUM_REQ - 1)
            return 3'd0;
        return id + 3'd1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] id);
        logic [7:0] oh;
        oh = 8'd1 << id;
        return oh[NUM_REQ-1:0];
    endfunction

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!pick_vld && req_ext[3'(idx)]) begin
                pick_vld = 1'b1;
                pick_id  = 3'(idx);
            end
        end
    end

    assign pick_byte    = data_ext[{pick_id, 3'b000} +: 8];
    assign own_byte     = data_ext[{grant_id, 3'b000} +: 8];
    assign own_continue = lock_ext[grant_id] && req_ext[grant_id] && (burst_cnt < MAX_BURST_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 3'd0;
            grant_id     <= 3'd0;
            burst_cnt    <= 8'd0;
            timer        <= 8'd0;
            uart_tx_byte <= 8'd0;
            req_ack      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            req_ack     <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id     <= pick_id;
                        uart_tx_byte <= pick_byte;
                        req_ack      <= onehot(pick_id);
                        burst_cnt    <= 8'd1;
                        state        <= START;
                    end
                end
                START: begin
                    timer <= 8'd0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart_is_transmitting) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        // UART never started: drop the byte and move fairness on.
                        timeout_err <= 1'b1;
                        rr_ptr      <= next_id(grant_id);
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_is_transmitting) begin
                        if (own_continue) begin
                            uart_tx_byte <= own_byte;
                            req_ack      <= onehot(grant_id);
                            burst_cnt    <= burst_cnt + 8'd1;
                            state        <= START;
                        end else begin
                            rr_ptr    <= next_id(grant_id);
                            burst_cnt <= 8'd0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uart_transmit = (state == START);
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = grant_id;
    assign bus.req_ack   = req_ack;

endmodule
